// File: rtl/mini_alu_seq.sv
// rtl/mini_alu_seq.sv - switch-driven sequential ALU with iterative shift-add multiply
module mini_alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH+1:0]   switches,
    output logic [2*WIDTH+1:0]   leds
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    state_t           state, state_next;
    logic             s1, s2, s3;
    logic             go;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [RW-1:0]    acc, acc_sum, alu_val, exec_val, result;
    logic [CW-1:0]    cnt;
    logic             busy, done;
    logic             last_iter, capture;

    assign go = s2 & ~s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= start;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        last_iter  = (op_q != OP_MUL) || (cnt == CW'(WIDTH - 1));
        case (state)
            IDLE, DONE: begin
                if (go) begin
                    state_next = EXEC;
                    capture    = 1'b1;
                end
            end
            EXEC: begin
                if (last_iter) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One shift-add step: add A shifted by the current multiplier bit position.
    always_comb begin
        acc_sum = acc;
        if (b_q[cnt]) acc_sum = acc + (RW'(a_q) << cnt);
        case (op_q)
            OP_ADD:  alu_val = RW'(a_q) + RW'(b_q);
            OP_SUB:  alu_val = RW'(a_q) - RW'(b_q);
            default: alu_val = RW'(a_q ^ b_q);
        endcase
        exec_val = (op_q == OP_MUL) ? acc_sum : alu_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 2'b00;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (capture) begin
            op_q <= switches[RW+1:RW];
            a_q  <= switches[RW-1:WIDTH];
            b_q  <= switches[WIDTH-1:0];
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (state == EXEC) begin
            if (last_iter) begin
                result <= exec_val;
                busy   <= 1'b0;
                done   <= 1'b1;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign leds = {done, busy, result};
endmodule

// File: tb/tb_mini_alu_seq.sv
// tb/tb_mini_alu_seq.sv - randomized cycle-exact bench for mini_alu_seq against a spec-level model
module tb_mini_alu_seq;
    localparam int W  = 4;
    localparam int LW = 2 * W + 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] switches;
    logic [LW-1:0] leds;

    int checks   = 0;
    int failures = 0;
    int last_res = 0;
    int last_done = 0;

    mini_alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .switches (switches),
        .leds     (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model(input int op, input int a, input int b);
        int mask;
        mask = (1 << (2 * W)) - 1;
        case (op)
            0:       return (a + b) & mask;
            1:       return (a - b) & mask;
            2:       return (a * b) & mask;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [31:0] led_word(input int d, input int b, input int r);
        return 32'((d << (2 * W + 1)) | (b << (2 * W)) | r);
    endfunction

    // Called just after a rising edge; that edge's successor is edge k (first sample of start).
    task automatic run(input string tag, input int op, input int a, input int b,
                       input int hold, input bit mid_pulse, input bit scramble);
        int lat, exp_res, span;
        lat     = (op == 2) ? W : 1;
        exp_res = model(op, a, b);
        span    = ((2 + lat) > hold ? (2 + lat) : hold) + 8;
        switches = LW'((op << (2 * W)) | (a << W) | b);
        start    = 1'b1;
        for (int e = 0; e <= span; e++) begin
            @(posedge clk);
            #1;
            if (e == hold - 1) start = 1'b0;
            if (mid_pulse && e == 3) start = 1'b1;
            if (mid_pulse && e == 4) start = 1'b0;
            if (scramble && e == 2) switches = LW'($urandom);
            if (e < 2)
                check({tag, "_pre"}, 32'(leds), led_word(last_done, 0, last_res));
            else if (e < 2 + lat)
                check({tag, "_busy"}, 32'(leds), led_word(0, 1, last_res));
            else
                check({tag, "_done"}, 32'(leds), led_word(1, 0, exp_res));
        end
        last_res  = exp_res;
        last_done = 1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        switches = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_leds", 32'(leds), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run("add", 0, 9, 8, 1, 0, 0);
        check("add_const", 32'(leds), 32'h211);
        run("sub_neg", 1, 3, 5, 1, 0, 0);
        check("sub_const", 32'(leds), 32'h2FE);
        run("sub_pos", 1, 5, 3, 1, 0, 0);
        run("mul_max", 2, 15, 15, 1, 0, 0);
        check("mul_const", 32'(leds), 32'h2E1);
        run("mul_zero", 2, 0, 11, 1, 0, 0);
        run("xor", 3, 10, 5, 1, 0, 0);
        run("restart", 0, 1, 1, 1, 0, 0);
        run("mul_hold", 2, 7, 13, 20, 0, 1);
        repeat (4) @(posedge clk);
        #1;
        run("mul_pulse", 2, 12, 9, 1, 1, 1);

        for (int i = 0; i < 25; i++)
            run("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(1, 3)), 0, 1);

        // Reset in the middle of a multiply.
        switches = LW'((2 << (2 * W)) | (15 << W) | 15);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midmul_busy", 32'(leds), led_word(0, 1, last_res));
        rst_n = 1'b0;
        #1;
        check("midmul_reset", 32'(leds), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res  = 0;
        last_done = 0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", 32'(leds), 32'h0);
        run("post_reset_mul", 2, 6, 11, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
